i2c_mem_slave: RTL and testbench
================================

Name: i2c_mem_slave

Overview:
I2C target that bridges a two-wire bus (SCL, open-drain SDA) to an 8-bit-address, 8-bit-data synchronous memory.
- Each transaction carries a device address plus R/W bit, a memory address byte, and a single data byte.
- On a read, the data byte comes from memory; on a write, the data byte is stored to memory.
- Bus lines are oversampled by clk8x, which runs at 8x or more the SCL rate.
- Sits between the I2C bus interface and the memory-bus interface.

Parameters:
- none; all widths are fixed at 8 bits.

Ports:
- clk8x  in  1  oversampling system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- id  in  8  device address; id[6:0] is compared against the received 7-bit address.
- SCL  in  1  I2C clock, driven by the master.
- SDA  inout  1  I2C data, open drain: the block drives only 0, otherwise Z.
- ce  out  1  memory chip enable.
- rden  out  1  memory read enable.
- wren  out  1  memory write enable.
- addr  out  8  memory address.
- wdata  out  8  memory write data.
- rdata  in  8  memory read data, valid 1 clk8x after ce&rden.
- state  out  4  current FSM state, for debug.
- data_buffer  out  8  current shift/data register, for debug.

Behaviour:
Reset (asynchronous, while reset=0):
- state=IDLE(0); SDA released (Z).
- ce, rden, wren = 0; addr, wdata, data_buffer = 0x00; bit counter = 0.

Bus sampling:
- SCL and SDA pass through a 2-flop synchronizer on clk8x.
- A rise or fall is detected by comparing the synced value with its previous sample.
- START = SDA falls while SCL high. STOP = SDA rises while SCL high. These are checked in every state and take priority.
- START (including a repeated START) goes to DEV_ADDR with bit counter=0. STOP goes to IDLE and releases SDA.

Bit timing:
- Master-driven bits are sampled on an SCL rising edge, MSB first.
- The slave changes SDA only on an SCL falling edge: it drives the next bit or ACK after the fall that ends the previous bit, and releases SDA on the fall that ends the ACK or data slot.

States (encoding):
- IDLE=0: wait for START.
- DEV_ADDR=1: shift in 8 bits (address[6:0], then R/W, with 1=read). After the 8th bit:
  - match (bits[7:1]==id[6:0]) -> latch R/W, go to ACK_DEV;
  - mismatch -> WAIT.
- ACK_DEV=2: drive SDA=0 for one SCL period, then MEM_ADDR.
- MEM_ADDR=3: shift in 8 bits. After the 8th rise, addr <= byte. Go to ACK_MEM.
- ACK_MEM=4: drive SDA=0 for one SCL period.
  - If read: pulse ce=rden=1 for exactly 1 clk8x, then load data_buffer <= rdata on the next clk8x. This completes before the ACK-ending SCL fall. Then TX_DATA.
  - If write: go to RX_DATA.
- TX_DATA=5: drive data_buffer MSB-first. The first bit is placed on the fall ending ACK_MEM. After 8 bits, release SDA and go to MACK.
- RX_DATA=6: shift 8 sampled bits into data_buffer. After the 8th bit:
  - wdata <= byte;
  - pulse ce=wren=1 for exactly 1 clk8x with addr held;
  - go to SACK.
- MACK=7: sample the master's ACK/NACK on the SCL rise. Either value goes to WAIT; there is no auto-increment.
- SACK=8: drive SDA=0 for one SCL period, then WAIT.
- WAIT=9: SDA released, SCL edges ignored. Only STOP or START exits.

Other rules:
- Exactly one data byte per transaction.
- Memory strobes are never asserted outside the pulses defined above.
- A START or STOP mid-byte aborts the transaction; no memory write occurs unless the 8th data bit was already sampled.
- Reset mid-transaction returns to IDLE immediately.

Test Plan:
1. Reset, then memory[1]=0x05, id=0x01. Send START, 0x03 (addr 1, read), mem addr 0x01, clock 8 bits, master ACK.
   -> Slave ACKs at both ACK slots; ce&rden pulse 1 cycle with addr=0x01; SDA carries 0x05 MSB-first; state ends at WAIT(9).
2. Repeated START, then 0x02 (write), mem addr 0x02, data 0x7F.
   -> Three slave ACKs; one ce&wren pulse with addr=0x02, wdata=0x7F; memory[2]=0x7F.
3. Repeated START, read of mem addr 0x02.
   -> SDA shows 0x7F; data_buffer=0x7F.
4. START, then address byte 0x05 (addr 2, which does not match id=1).
   -> No ACK (SDA stays Z); no memory strobe; state=WAIT until STOP, then IDLE.
5. Write transaction with STOP after 4 data bits.
   -> wren never asserted; state=IDLE.
6. Assert reset=0 during TX_DATA.
   -> state=0, SDA released, all strobes 0 immediately (asynchronous).

Source files
------------

// File: rtl/i2c_mem_slave.sv
// rtl/i2c_mem_slave.sv - I2C target bridging a two-wire bus to an 8-bit synchronous memory
module i2c_mem_slave (
  input  logic       clk8x,
  input  logic       reset,
  input  logic [7:0] id,
  input  logic       SCL,
  inout  wire        SDA,
  output logic       ce,
  output logic       rden,
  output logic       wren,
  output logic [7:0] addr,
  output logic [7:0] wdata,
  input  logic [7:0] rdata,
  output logic [3:0] state,
  output logic [7:0] data_buffer
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    DEV_ADDR = 4'd1,
    ACK_DEV  = 4'd2,
    MEM_ADDR = 4'd3,
    ACK_MEM  = 4'd4,
    TX_DATA  = 4'd5,
    RX_DATA  = 4'd6,
    MACK     = 4'd7,
    SACK     = 4'd8,
    WAIT     = 4'd9
  } state_t;

  state_t     cur_state, nxt_state;
  logic [3:0] bit_cnt, nxt_cnt, cnt_inc;
  logic [7:0] nxt_buf, nxt_addr, nxt_wdata, shift_byte;
  logic       rw, nxt_rw;
  logic       sda_drive, nxt_drive;
  logic [1:0] rd_step, nxt_rd_step;
  logic       nxt_ce, nxt_rden, nxt_wren;

  logic scl_s1, scl_s2, scl_prev;
  logic sda_s1, sda_s2, sda_prev;
  logic scl_rise, scl_fall, start_det, stop_det;

  // The 8th address bit is the R/W flag, so id[7] plays no part in matching.
  logic unused_id_msb;
  assign unused_id_msb = id[7];

  // Open drain: only ever pull low, otherwise let the pull-up win.
  assign SDA   = sda_drive ? 1'b0 : 1'bz;
  assign state = cur_state;

  // Two-flop synchronizers plus one history flop for edge detection; idle bus is high.
  always_ff @(posedge clk8x or negedge reset) begin
    if (!reset) begin
      scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_prev <= 1'b1;
      sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_prev <= 1'b1;
    end else begin
      scl_s1 <= SCL;    scl_s2 <= scl_s1; scl_prev <= scl_s2;
      sda_s1 <= SDA;    sda_s2 <= sda_s1; sda_prev <= sda_s2;
    end
  end

  assign scl_rise   = scl_s2 & ~scl_prev;
  assign scl_fall   = ~scl_s2 & scl_prev;
  assign start_det  = scl_s2 & scl_prev & ~sda_s2 & sda_prev;
  assign stop_det   = scl_s2 & scl_prev & sda_s2 & ~sda_prev;
  assign shift_byte = {data_buffer[6:0], sda_s2};

  // State and datapath registers.
  always_ff @(posedge clk8x or negedge reset) begin
    if (!reset) begin
      cur_state   <= IDLE;
      bit_cnt     <= 4'd0;
      data_buffer <= 8'h00;
      addr        <= 8'h00;
      wdata       <= 8'h00;
      rw          <= 1'b0;
      sda_drive   <= 1'b0;
      rd_step     <= 2'd0;
      ce          <= 1'b0;
      rden        <= 1'b0;
      wren        <= 1'b0;
    end else begin
      cur_state   <= nxt_state;
      bit_cnt     <= nxt_cnt;
      data_buffer <= nxt_buf;
      addr        <= nxt_addr;
      wdata       <= nxt_wdata;
      rw          <= nxt_rw;
      sda_drive   <= nxt_drive;
      rd_step     <= nxt_rd_step;
      ce          <= nxt_ce;
      rden        <= nxt_rden;
      wren        <= nxt_wren;
    end
  end

  // Next-state and datapath updates; START/STOP override whatever the current state wants.
  always_comb begin
    nxt_state   = cur_state;
    nxt_cnt     = bit_cnt;
    nxt_buf     = data_buffer;
    nxt_addr    = addr;
    nxt_wdata   = wdata;
    nxt_rw      = rw;
    nxt_drive   = sda_drive;
    nxt_rd_step = rd_step;
    nxt_ce      = 1'b0;
    nxt_rden    = 1'b0;
    nxt_wren    = 1'b0;
    cnt_inc     = bit_cnt + 4'd1;

    if (start_det) begin
      nxt_state = DEV_ADDR;
      nxt_cnt   = 4'd0;
      nxt_drive = 1'b0;
    end else if (stop_det) begin
      nxt_state = IDLE;
      nxt_drive = 1'b0;
    end else begin
      case (cur_state)
        DEV_ADDR: if (scl_rise) begin
          nxt_buf = shift_byte;
          nxt_cnt = cnt_inc;
          if (bit_cnt == 4'd7) begin
            if (data_buffer[6:0] == id[6:0]) begin
              nxt_rw    = sda_s2;
              nxt_state = ACK_DEV;
            end else begin
              nxt_state = WAIT;
            end
          end
        end
        // First fall pulls SDA low, the next fall ends the ACK slot.
        ACK_DEV: if (scl_fall) begin
          if (!sda_drive) begin
            nxt_drive = 1'b1;
          end else begin
            nxt_drive = 1'b0;
            nxt_cnt   = 4'd0;
            nxt_state = MEM_ADDR;
          end
        end
        MEM_ADDR: if (scl_rise) begin
          nxt_buf = shift_byte;
          nxt_cnt = cnt_inc;
          if (bit_cnt == 4'd7) begin
            nxt_addr    = shift_byte;
            nxt_rd_step = 2'd0;
            nxt_state   = ACK_MEM;
          end
        end
        ACK_MEM: begin
          if (scl_fall) begin
            if (!sda_drive) begin
              nxt_drive = 1'b1;
            end else if (rw) begin
              nxt_drive = ~data_buffer[7];
              nxt_cnt   = 4'd0;
              nxt_state = TX_DATA;
            end else begin
              nxt_drive = 1'b0;
              nxt_cnt   = 4'd0;
              nxt_state = RX_DATA;
            end
          end else if (rw && sda_drive) begin
            // Memory fetch runs while SCL is low in the ACK slot: strobe, wait, capture.
            case (rd_step)
              2'd0: begin
                nxt_ce      = 1'b1;
                nxt_rden    = 1'b1;
                nxt_rd_step = 2'd1;
              end
              2'd1: nxt_rd_step = 2'd2;
              2'd2: begin
                nxt_buf     = rdata;
                nxt_rd_step = 2'd3;
              end
              default: ;
            endcase
          end
        end
        // data_buffer stays intact; the bit counter picks which bit to present.
        TX_DATA: if (scl_fall) begin
          nxt_cnt = cnt_inc;
          if (bit_cnt == 4'd7) begin
            nxt_drive = 1'b0;
            nxt_state = MACK;
          end else begin
            nxt_drive = ~data_buffer[~cnt_inc[2:0]];
          end
        end
        RX_DATA: if (scl_rise) begin
          nxt_buf = shift_byte;
          nxt_cnt = cnt_inc;
          if (bit_cnt == 4'd7) begin
            nxt_wdata = shift_byte;
            nxt_ce    = 1'b1;
            nxt_wren  = 1'b1;
            nxt_state = SACK;
          end
        end
        MACK: if (scl_rise) nxt_state = WAIT;
        SACK: if (scl_fall) begin
          if (!sda_drive) begin
            nxt_drive = 1'b1;
          end else begin
            nxt_drive = 1'b0;
            nxt_state = WAIT;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_mem_slave.sv
// tb/tb_i2c_mem_slave.sv - self-checking bench for i2c_mem_slave
module tb_i2c_mem_slave;

  logic       clk8x = 1'b0;
  logic       reset;
  logic [7:0] id;
  logic       SCL;
  logic       sda_m;
  wire        SDA;
  logic       ce, rden, wren;
  logic [7:0] addr, wdata, rdata, data_buffer;
  logic [3:0] state;

  logic [7:0] mem [256];
  int rd_cyc = 0, wr_cyc = 0, stray = 0;
  logic [7:0] last_rd_addr = 8'h00, last_wr_addr = 8'h00;

  int n_checks = 0;
  int n_fail = 0;

  assign SDA = sda_m ? 1'bz : 1'b0;
  pullup(SDA);

  always #5 clk8x = ~clk8x;

  i2c_mem_slave dut (
    .clk8x(clk8x), .reset(reset), .id(id), .SCL(SCL), .SDA(SDA),
    .ce(ce), .rden(rden), .wren(wren), .addr(addr), .wdata(wdata),
    .rdata(rdata), .state(state), .data_buffer(data_buffer)
  );

  // Behavioural synchronous memory plus strobe bookkeeping.
  always @(posedge clk8x) begin
    if (ce && rden) begin
      rdata <= mem[addr];
      rd_cyc <= rd_cyc + 1;
      last_rd_addr <= addr;
    end
    if (ce && wren) begin
      mem[addr] <= wdata;
      wr_cyc <= wr_cyc + 1;
      last_wr_addr <= addr;
    end
    if (((rden || wren) && !ce) || (ce && !(rden ^ wren)))
      stray <= stray + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk8x);
  endtask

  task automatic send_bit(input logic b, output logic s);
    SCL = 1'b0; tick(4);
    sda_m = b;  tick(4);
    SCL = 1'b1; tick(4);
    s = SDA;    tick(4);
  endtask

  task automatic i2c_start();
    SCL = 1'b0;   tick(4);
    sda_m = 1'b1; tick(4);
    SCL = 1'b1;   tick(4);
    sda_m = 1'b0; tick(4);
  endtask

  task automatic i2c_stop();
    SCL = 1'b0;   tick(4);
    sda_m = 1'b0; tick(4);
    SCL = 1'b1;   tick(4);
    sda_m = 1'b1; tick(4);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], s);
    send_bit(1'b1, ack);
  endtask

  task automatic read_byte(output logic [7:0] b, input logic mack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, s);
      b[i] = s;
    end
    send_bit(mack, s);
  endtask

  typedef struct {
    logic [7:0] dev;
    logic [7:0] maddr;
    logic [7:0] wbyte;
    logic       exp_dev_ack;
    logic [7:0] exp_rbyte;
    int         exp_rd;
    int         exp_wr;
    logic [3:0] exp_state;
    logic       stop_after;
  } vec_t;

  vec_t vecs [4];

  initial begin
    logic       ack, s0, s1;
    logic [7:0] rb;
    int         rd0, wr0;

    vecs[0] = '{8'h03, 8'h01, 8'h00, 1'b0, 8'h05, 1, 0, 4'd9, 1'b0};
    vecs[1] = '{8'h02, 8'h02, 8'h7F, 1'b0, 8'h00, 0, 1, 4'd9, 1'b0};
    vecs[2] = '{8'h03, 8'h02, 8'h00, 1'b0, 8'h7F, 1, 0, 4'd9, 1'b1};
    vecs[3] = '{8'h05, 8'h00, 8'h00, 1'b1, 8'h00, 0, 0, 4'd9, 1'b1};

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[1] = 8'h05;
    id     = 8'h01;
    SCL    = 1'b1;
    sda_m  = 1'b1;
    reset  = 1'b0;
    tick(3);

    check("reset_state", 8'(state), 8'h00);
    check("reset_ce", 8'(ce), 8'h00);
    check("reset_rden", 8'(rden), 8'h00);
    check("reset_wren", 8'(wren), 8'h00);
    check("reset_addr", addr, 8'h00);
    check("reset_wdata", wdata, 8'h00);
    check("reset_data_buffer", data_buffer, 8'h00);
    check("reset_sda", 8'(SDA), 8'h01);

    reset = 1'b1;
    tick(4);

    for (int i = 0; i < 4; i++) begin
      rd0 = rd_cyc;
      wr0 = wr_cyc;
      i2c_start();
      check("start_state", 8'(state), 8'h01);
      write_byte(vecs[i].dev, ack);
      check("dev_ack", 8'(ack), 8'(vecs[i].exp_dev_ack));
      if (!vecs[i].exp_dev_ack) begin
        write_byte(vecs[i].maddr, ack);
        check("maddr_ack", 8'(ack), 8'h00);
        check("addr_reg", addr, vecs[i].maddr);
        if (vecs[i].dev[0]) begin
          read_byte(rb, 1'b0);
          check("read_byte", rb, vecs[i].exp_rbyte);
          check("read_data_buffer", data_buffer, vecs[i].exp_rbyte);
          check("read_strobe_addr", last_rd_addr, vecs[i].maddr);
        end else begin
          write_byte(vecs[i].wbyte, ack);
          check("data_ack", 8'(ack), 8'h00);
          check("wdata_reg", wdata, vecs[i].wbyte);
          check("mem_written", mem[vecs[i].maddr], vecs[i].wbyte);
          check("write_strobe_addr", last_wr_addr, vecs[i].maddr);
        end
        SCL = 1'b0;
        tick(6);
      end
      check("end_state", 8'(state), 8'(vecs[i].exp_state));
      check("rden_cycles", 8'(rd_cyc - rd0), 8'(vecs[i].exp_rd));
      check("wren_cycles", 8'(wr_cyc - wr0), 8'(vecs[i].exp_wr));
      if (vecs[i].stop_after) begin
        i2c_stop();
        check("stop_idle", 8'(state), 8'h00);
      end
    end

    // Write aborted by STOP after four data bits.
    wr0 = wr_cyc;
    i2c_start();
    write_byte(8'h02, ack);
    check("abort_dev_ack", 8'(ack), 8'h00);
    write_byte(8'h10, ack);
    check("abort_maddr_ack", 8'(ack), 8'h00);
    send_bit(1'b1, s0);
    send_bit(1'b0, s0);
    send_bit(1'b1, s0);
    send_bit(1'b0, s0);
    check("abort_rx_state", 8'(state), 8'h06);
    i2c_stop();
    check("abort_idle", 8'(state), 8'h00);
    check("abort_no_wren", 8'(wr_cyc - wr0), 8'h00);
    check("abort_mem_untouched", mem[8'h10], 8'h00);

    // Asynchronous reset while the slave is driving a data bit low.
    i2c_start();
    write_byte(8'h03, ack);
    check("rst_dev_ack", 8'(ack), 8'h00);
    write_byte(8'h01, ack);
    check("rst_maddr_ack", 8'(ack), 8'h00);
    send_bit(1'b1, s0);
    send_bit(1'b1, s1);
    check("rst_tx_bits", 8'({s0, s1}), 8'h00);
    SCL = 1'b0;
    tick(6);
    check("rst_tx_state", 8'(state), 8'h05);
    check("rst_tx_sda_low", 8'(SDA), 8'h00);
    #2 reset = 1'b0;
    #1;
    check("async_state", 8'(state), 8'h00);
    check("async_sda", 8'(SDA), 8'h01);
    check("async_ce", 8'(ce), 8'h00);
    check("async_rden", 8'(rden), 8'h00);
    check("async_wren", 8'(wren), 8'h00);
    tick(2);
    reset = 1'b1;
    SCL = 1'b1;
    tick(4);

    check("stray_strobes", 8'(stray), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
